// File: rtl/prog_timer_bank.sv
// prog_timer_bank: NUM_CH loadable down-counting interval timers that share
// one clock-enable prescaler. The controller loads a duration and waits for
// a one-cycle expired pulse. Each channel can pause, and can run one-shot or
// auto-reload.

// One timer channel. It advances only on the shared tick.
module prog_timer_ch #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] reload_reg;

    // Load has priority over a decrement. A zero-length load expires at once.
    // Auto-reload is sampled on the expiring tick, not when the load happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            expired    <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                reload_reg <= load_val;
                count      <= load_val;
                state      <= (load_val != '0) ? ST_RUN : ST_IDLE;
                expired    <= (load_val == '0);
            end else if (state == ST_RUN && tick && !pause) begin
                if (count > WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else if (count == WIDTH'(1)) begin
                    expired <= 1'b1;
                    if (auto_reload) begin
                        count <= reload_reg;
                    end else begin
                        count <= '0;
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign running = (state == ST_RUN);
endmodule

module prog_timer_bank #(
    parameter int WIDTH    = 6,
    parameter int NUM_CH   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ps_clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH-1:0]       auto_reload,
    input  logic [NUM_CH-1:0]       pause,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       expired
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]                ps_cnt;
    logic                           tick;
    logic [NUM_CH-1:0][WIDTH-1:0]   lv_arr;
    logic [NUM_CH-1:0][WIDTH-1:0]   cnt_arr;

    assign lv_arr = load_val;
    assign count  = cnt_arr;

    // A clear suppresses the tick in the cycle it is asserted.
    assign tick = (ps_cnt == PS_MAX) && !ps_clr;

    // Shared free-running prescaler. It is not restarted by a channel load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ps_cnt <= '0;
        else if (ps_clr)           ps_cnt <= '0;
        else if (ps_cnt == PS_MAX) ps_cnt <= '0;
        else                       ps_cnt <= ps_cnt + PS_W'(1);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        prog_timer_ch #(.WIDTH(WIDTH)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .load        (load[gi]),
            .load_val    (lv_arr[gi]),
            .auto_reload (auto_reload[gi]),
            .pause       (pause[gi]),
            .count       (cnt_arr[gi]),
            .running     (running[gi]),
            .expired     (expired[gi])
        );
    end
endmodule

// File: tb/tb_prog_timer_bank.sv
// Testbench for prog_timer_bank. It runs a PRESCALE=1 bank (a) and a
// PRESCALE=4 bank (b) side by side on the same stimulus. A behavioural model
// of both banks is checked against the outputs every cycle. Directed literal
// checks pin the key sequences.
module tb_prog_timer_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps_clr = 1'b0;
    logic [1:0]  load = '0;
    logic [11:0] lv = '0;
    logic [1:0]  ar = '0;
    logic [1:0]  pause = '0;
    logic [11:0] count_a, count_b;
    logic [1:0]  running_a, running_b, expired_a, expired_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    prog_timer_bank #(.WIDTH(6), .NUM_CH(2), .PRESCALE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ps_clr(ps_clr), .load(load), .load_val(lv),
        .auto_reload(ar), .pause(pause), .count(count_a), .running(running_a),
        .expired(expired_a));

    prog_timer_bank #(.WIDTH(6), .NUM_CH(2), .PRESCALE(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ps_clr(ps_clr), .load(load), .load_val(lv),
        .auto_reload(ar), .pause(pause), .count(count_b), .running(running_b),
        .expired(expired_b));

    // Model state: m = bank (0: P=1, 1: P=4), second index = channel.
    int mrem[2][2];
    int mrld[2][2];
    bit mact[2][2];
    bit mpul[2][2];
    int since[2];

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: a tick falls every P cycles, counted from reset or from the last clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                since[m] = 0;
                for (int c = 0; c < 2; c++) begin
                    mrem[m][c] = 0; mrld[m][c] = 0; mact[m][c] = 0; mpul[m][c] = 0;
                end
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int p;
                bit tk;
                p  = (m == 0) ? 1 : 4;
                tk = !ps_clr && ((since[m] % p) == p - 1);
                since[m] = ps_clr ? 0 : since[m] + 1;
                for (int c = 0; c < 2; c++) begin
                    int v;
                    v = int'(lv[c*6 +: 6]);
                    mpul[m][c] = 0;
                    if (load[c]) begin
                        mrld[m][c] = v;
                        mrem[m][c] = v;
                        mact[m][c] = (v != 0);
                        mpul[m][c] = (v == 0);
                    end else if (mact[m][c] && tk && !pause[c]) begin
                        mrem[m][c] = mrem[m][c] - 1;
                        if (mrem[m][c] == 0) begin
                            mpul[m][c] = 1;
                            if (ar[c]) mrem[m][c] = mrld[m][c];
                            else       mact[m][c] = 0;
                        end
                    end
                end
            end
        end
    end

    function automatic int m_cnt(input int m);
        return mrem[m][1] * 64 + mrem[m][0];
    endfunction
    function automatic int m_run(input int m);
        return int'(mact[m][1]) * 2 + int'(mact[m][0]);
    endfunction
    function automatic int m_exp(input int m);
        return int'(mpul[m][1]) * 2 + int'(mpul[m][0]);
    endfunction

    // Check both banks against the model on every falling edge.
    always @(negedge clk) begin
        chk("cmp_count_a",   int'(count_a),   m_cnt(0));
        chk("cmp_running_a", int'(running_a), m_run(0));
        chk("cmp_expired_a", int'(expired_a), m_exp(0));
        chk("cmp_count_b",   int'(count_b),   m_cnt(1));
        chk("cmp_running_b", int'(running_b), m_run(1));
        chk("cmp_expired_b", int'(expired_b), m_exp(1));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int ca(input int ch);
        return int'(count_a[ch*6 +: 6]);
    endfunction

    initial begin
        int e0[5]  = '{4, 3, 2, 1, 0};
        int e1[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
        int e2[4]  = '{3, 2, 1, 0};

        // Reset state.
        step(2);
        chk("rst_count", int'(count_a), 0);
        chk("rst_running", int'(running_a), 0);
        chk("rst_expired", int'(expired_a), 0);
        rst_n = 1'b1;
        step(1);

        // One-shot countdown from 5 on channel 0.
        lv[5:0] = 6'd5; load = 2'b01; step(1); load = '0;
        chk("os_load_count", ca(0), 5);
        chk("os_load_run", int'(running_a[0]), 1);
        chk("model_pin_load", mrem[0][0], 5);
        foreach (e0[i]) begin
            step(1);
            chk("os_count", ca(0), e0[i]);
        end
        chk("os_expired", int'(expired_a[0]), 1);
        chk("os_run_fall", int'(running_a[0]), 0);
        step(1);
        chk("os_pulse_one", int'(expired_a[0]), 0);

        // Auto-reload countdown from 3 on channel 1.
        ar = 2'b10; lv[11:6] = 6'd3; load = 2'b10; step(1); load = '0;
        chk("ar_load_count", ca(1), 3);
        foreach (e1[i]) begin
            step(1);
            chk("ar_count", ca(1), e1[i]);
            chk("ar_expired", int'(expired_a[1]), (e1[i] == 3) ? 1 : 0);
            chk("ar_running", int'(running_a[1]), 1);
        end
        // A zero-length load stops the channel and pulses expired.
        ar = '0; lv[11:6] = 6'd0; load = 2'b10; step(1); load = '0;
        chk("zero_load_exp", int'(expired_a[1]), 1);
        chk("zero_load_run", int'(running_a[1]), 0);
        step(1);
        chk("zero_load_pulse_one", int'(expired_a[1]), 0);

        // Pause holds the count at 4 without expiring.
        lv[5:0] = 6'd6; load = 2'b01; step(1); load = '0;
        step(2);
        chk("pause_pre", ca(0), 4);
        pause = 2'b01;
        step(6);
        chk("pause_hold", ca(0), 4);
        chk("pause_running", int'(running_a[0]), 1);
        pause = '0;
        foreach (e2[i]) begin
            step(1);
            chk("pause_resume", ca(0), e2[i]);
        end
        chk("pause_expired", int'(expired_a[0]), 1);

        // Reload in the middle of a run.
        lv[5:0] = 6'd4; load = 2'b01; step(1); load = '0;
        step(2);
        chk("rl_pre", ca(0), 2);
        lv[5:0] = 6'd7; load = 2'b01; step(1); load = '0;
        chk("rl_count", ca(0), 7);
        chk("rl_no_exp", int'(expired_a[0]), 0);
        step(1);
        chk("rl_dec", ca(0), 6);
        lv[5:0] = 6'd0; load = 2'b01; step(1); load = '0;
        chk("rl0_exp", int'(expired_a[0]), 1);
        chk("rl0_run", int'(running_a[0]), 0);
        chk("rl0_count", ca(0), 0);

        // Bank b (P=4): clear the prescaler, then load 2. Expect expiry 8 edges later.
        ps_clr = 1'b1; lv[5:0] = 6'd2; load = 2'b01; step(1);
        ps_clr = 1'b0; load = '0;
        chk("ps4_load", int'(count_b[5:0]), 2);
        step(7);
        chk("ps4_mid", int'(count_b[5:0]), 1);
        chk("ps4_no_exp", int'(expired_b[0]), 0);
        step(1);
        chk("ps4_count0", int'(count_b[5:0]), 0);
        chk("ps4_exp", int'(expired_b[0]), 1);

        // Assert reset while both channels are running at count 1.
        lv = {6'd2, 6'd2}; ar = '0; load = 2'b11; step(1); load = '0;
        step(1);
        chk("mid_pre0", ca(0), 1);
        chk("mid_pre1", ca(1), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", int'(count_a), 0);
        chk("mid_rst_run", int'(running_a), 0);
        chk("mid_rst_exp", int'(expired_a), 0);
        chk("mid_rst_count_b", int'(count_b), 0);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("post_rst_no_exp", int'(expired_a), 0);
        end

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
